// File: rtl/cla_seq.sv
// cla_seq: host-side operand sequencer for the registered CLA add/sub unit; done at E0+4+SETTLE_CYCLES, ready only in IDLE.
// Optional CLA_SEQ_CHECK_EN adds a mismatch output comparing the captured alu_r with a local add/sub model.
module cla_seq #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_sub,
  input  logic             abort,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags_znvc,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_addsub,
  output logic             alu_load,
  output logic             alu_submit,
  input  logic [WIDTH-1:0] alu_r,
  input  logic [3:0]       alu_flags
`ifdef CLA_SEQ_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SETTLE = 3'd2,
    SUBMIT = 3'd3,
    CAPT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       accept;

  assign accept = (state == IDLE) && start && !abort;

`ifdef CLA_SEQ_CHECK_EN
  logic [WIDTH-1:0] expected;
  assign expected = alu_addsub ? (alu_a - alu_b) : (alu_a + alu_b);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_addsub <= 1'b0;
      result     <= '0;
      flags_znvc <= '0;
`ifdef CLA_SEQ_CHECK_EN
      mismatch   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // cnt is loaded in LOAD so SETTLE sees the full count on its first cycle
      if (state == LOAD) begin
        cnt <= SETTLE_INIT;
      end else if (state == SETTLE) begin
        cnt <= cnt - 4'd1;
      end
      if (accept) begin
        alu_a      <= op_a;
        alu_b      <= op_b;
        alu_addsub <= op_sub;
      end
      if ((state == CAPT) && !abort) begin
        result     <= alu_r;
        flags_znvc <= alu_flags;
`ifdef CLA_SEQ_CHECK_EN
        mismatch   <= (alu_r != expected);
`endif
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    ready      = 1'b0;
    done       = 1'b0;
    alu_load   = 1'b0;
    alu_submit = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (accept) state_nxt = LOAD;
      end
      LOAD: begin
        alu_load  = 1'b1;
        state_nxt = (SETTLE_INIT == 4'd0) ? SUBMIT : SETTLE;
      end
      SETTLE: begin
        if (cnt <= 4'd1) state_nxt = SUBMIT;
      end
      SUBMIT: begin
        alu_submit = 1'b1;
        state_nxt  = CAPT;
      end
      CAPT: begin
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

endmodule

// File: tb/tb_cla_seq.sv
// Bench for cla_seq: two instances (SETTLE_CYCLES 2 and 0) checked every cycle against a timeline model.
module tb_cla_seq;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       start_v;
  logic             abort;
  logic [3:0]       op_a, op_b;
  logic             op_sub;
  logic [3:0]       alu_r, alu_flags;

  logic [1:0]       ready, done, alu_addsub, alu_load, alu_submit;
  logic [1:0][3:0]  result, flags_znvc, alu_a, alu_b;
`ifdef CLA_SEQ_CHECK_EN
  logic [1:0]       mismatch;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  cla_seq #(.WIDTH(4), .SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .reset(rst), .start(start_v[0]), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .abort(abort), .ready(ready[0]), .done(done[0]), .result(result[0]), .flags_znvc(flags_znvc[0]),
    .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_addsub(alu_addsub[0]), .alu_load(alu_load[0]),
    .alu_submit(alu_submit[0]), .alu_r(alu_r), .alu_flags(alu_flags)
`ifdef CLA_SEQ_CHECK_EN
    , .mismatch(mismatch[0])
`endif
  );

  cla_seq #(.WIDTH(4), .SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .reset(rst), .start(start_v[1]), .op_a(op_a), .op_b(op_b), .op_sub(op_sub),
    .abort(abort), .ready(ready[1]), .done(done[1]), .result(result[1]), .flags_znvc(flags_znvc[1]),
    .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_addsub(alu_addsub[1]), .alu_load(alu_load[1]),
    .alu_submit(alu_submit[1]), .alu_r(alu_r), .alu_flags(alu_flags)
`ifdef CLA_SEQ_CHECK_EN
    , .mismatch(mismatch[1])
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  // Reference add/sub unit: {Z,N,V,C, r}; C is the carry out of a + (sub ? ~b + 1 : b).
  function automatic logic [7:0] unit(input logic [3:0] a, input logic [3:0] b, input logic sub);
    logic [4:0] s;
    logic [3:0] bb, r;
    logic       v;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {4'd0, sub};
    r  = s[3:0];
    v  = (a[3] == bb[3]) && (r[3] != a[3]);
    return {(r == 4'd0), r[3], v, s[4], r};
  endfunction

  // Timeline model: an accepted op at edge k0 occupies phases 0..S+3 after edges k0..k0+S+3.
  logic [1:0]      m_act;
  int              m_k0 [2];
  logic [1:0][3:0] m_a, m_b, m_res, m_flg;
  logic [1:0]      m_sub, m_mis;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] <= 1'b0; m_a[i] <= '0; m_b[i] <= '0; m_sub[i] <= 1'b0;
        m_res[i] <= '0; m_flg[i] <= '0; m_mis[i] <= 1'b0; m_k0[i] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (!m_act[i]) begin
          if (start_v[i] && !abort) begin
            m_act[i] <= 1'b1; m_k0[i] <= cyc;
            m_a[i] <= op_a; m_b[i] <= op_b; m_sub[i] <= op_sub;
          end
        end else if (abort || (cyc - m_k0[i] == settle_of(i) + 4)) begin
          m_act[i] <= 1'b0;
        end else if (cyc - m_k0[i] == settle_of(i) + 3) begin
          m_res[i] <= alu_r;
          m_flg[i] <= alu_flags;
          m_mis[i] <= (alu_r != (m_sub[i] ? m_a[i] - m_b[i] : m_a[i] + m_b[i]));
        end
      end
    end
  end

  int ph;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        ph = cyc - 1 - m_k0[i];
        chk($sformatf("ready[%0d]", i), ready[i], !m_act[i]);
        chk($sformatf("alu_load[%0d]", i), alu_load[i], m_act[i] && ph == 0);
        chk($sformatf("alu_submit[%0d]", i), alu_submit[i], m_act[i] && ph == settle_of(i) + 1);
        chk($sformatf("done[%0d]", i), done[i], m_act[i] && ph == settle_of(i) + 3);
        chk($sformatf("result[%0d]", i), result[i], m_res[i]);
        chk($sformatf("flags[%0d]", i), flags_znvc[i], m_flg[i]);
        chk($sformatf("alu_a[%0d]", i), alu_a[i], m_a[i]);
        chk($sformatf("alu_b[%0d]", i), alu_b[i], m_b[i]);
        chk($sformatf("alu_addsub[%0d]", i), alu_addsub[i], m_sub[i]);
`ifdef CLA_SEQ_CHECK_EN
        chk($sformatf("mismatch[%0d]", i), mismatch[i], m_mis[i]);
`endif
      end
    end
  end

  // Drives one op for one cycle; returns at the negedge after the accepting edge (phase 0).
  task automatic issue(input int d, input logic [3:0] a, input logic [3:0] b, input logic sub,
                       input bit use_ovr, input logic [3:0] r_ovr);
    @(negedge clk);
    op_a = a; op_b = b; op_sub = sub;
    {alu_flags, alu_r} = unit(a, b, sub);
    if (use_ovr) alu_r = r_ovr;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    chk("load_at_E0+1", alu_load[d], 1);
  endtask

  // Negedge index (1 = phase 0) at which submit and done are first seen; 0 means never.
  task automatic wait_done(input int d, output int t_sub, output int t_done);
    t_sub = 0; t_done = 0;
    for (int k = 1; k <= 20; k++) begin
      if (alu_submit[d] && t_sub == 0) t_sub = k;
      if (done[d]) begin
        t_done = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int ts, td, ndone;

  initial begin
    rst = 1'b0; start_v = '0; abort = 1'b0; op_a = '0; op_b = '0; op_sub = 1'b0;
    alu_r = '0; alu_flags = '0;

    // asynchronous reset asserted mid-cycle
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", ready[0], 1);
    chk("rst_done", done[0], 0);
    chk("rst_result", result[0], 0);
    chk("rst_flags", flags_znvc[0], 0);
    chk("rst_load", alu_load[0], 0);
    chk("rst_submit", alu_submit[0], 0);
    @(negedge clk); @(negedge clk);
    #3 rst = 1'b0;

    // single add, default settle
    issue(0, 4'd3, 4'd4, 1'b0, 1'b0, 4'd0);
    chk("add_alu_a", alu_a[0], 3);
    chk("add_alu_b", alu_b[0], 4);
    wait_done(0, ts, td);
    chk("add_submit_lat", ts, 4);
    chk("add_done_lat", td, 6);
    chk("add_result", result[0], 7);
    chk("add_flags", flags_znvc[0], 4'b0000);

    // start during SETTLE is ignored
    issue(0, 4'd3, 4'd4, 1'b0, 1'b0, 4'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin op_a = 4'd9; start_v[0] = 1'b1; end
      if (k == 2) start_v[0] = 1'b0;
      if (done[0]) ndone++;
      @(negedge clk);
    end
    chk("busy_alu_a", alu_a[0], 3);
    chk("busy_done_count", ndone, 1);

    // abort in SUBMIT
    issue(0, 4'd5, 4'd5, 1'b0, 1'b0, 4'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("abort_in_submit", alu_submit[0], 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", ready[0], 1);
    chk("abort_result_hold", result[0], 7);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done[0]) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", ndone, 0);

    // zero settle instance
    issue(1, 4'd15, 4'd1, 1'b0, 1'b0, 4'd0);
    wait_done(1, ts, td);
    chk("s0_submit_lat", ts, 2);
    chk("s0_done_lat", td, 4);
    chk("s0_result", result[1], 0);
    chk("s0_flags", flags_znvc[1], 4'b1001);

    // wrong and right results from the unit for 8-3
    issue(0, 4'd8, 4'd3, 1'b1, 1'b1, 4'd11);
    wait_done(0, ts, td);
    chk("bad_done_lat", td, 6);
    chk("bad_result", result[0], 11);
`ifdef CLA_SEQ_CHECK_EN
    chk("bad_mismatch", mismatch[0], 1);
`endif
    issue(0, 4'd8, 4'd3, 1'b1, 1'b1, 4'd5);
    wait_done(0, ts, td);
    chk("good_result", result[0], 5);
`ifdef CLA_SEQ_CHECK_EN
    chk("good_mismatch", mismatch[0], 0);
`endif

    // asynchronous reset mid-operation, during LOAD->SETTLE
    issue(0, 4'd6, 4'd1, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ready", ready[0], 1);
    chk("midrst_load", alu_load[0], 0);
    chk("midrst_submit", alu_submit[0], 0);
    chk("midrst_result", result[0], 0);
    chk("midrst_alu_a", alu_a[0], 0);
    @(negedge clk);
    #3 rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
